jtag_debug_port: RTL and testbench

//  Parametrised successor JTAG-style debug port. Parses TCK/TMS/TDI into a 6-state shift machine.

---
 rtl/jtag_dbg_pkg.sv | 27 ++
 rtl/jtag_debug_port_fsm.sv | 52 +++++
 rtl/jtag_debug_port.sv | 119 +++++++++++
 tb/tb_jtag_debug_port.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dbg_pkg.sv
// Shared encodings for the JTAG debug port:
// TAP states, command codes and status-word bit positions.
package jtag_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_ISEL   = 3'b001,
    ST_ISHFT  = 3'b100,
    ST_DSEL   = 3'b101,
    ST_DSHFT  = 3'b010,
    ST_UPDATE = 3'b110
  } state_t;

  localparam logic [2:0] CMD_NOP     = 3'b000;
  localparam logic [2:0] CMD_SETADDR = 3'b001;
  localparam logic [2:0] CMD_READ    = 3'b010;
  localparam logic [2:0] CMD_WRITE   = 3'b011;
  localparam logic [2:0] CMD_PAUSE   = 3'b100;
  localparam logic [2:0] CMD_RUN     = 3'b101;
  localparam logic [2:0] CMD_RDINC   = 3'b110;
  localparam logic [2:0] CMD_WRINC   = 3'b111;

  localparam int STS_BOOTED = 0;
  localparam int STS_PAUSED = 1;
  localparam int STS_ERR    = 2;

endpackage

// File: rtl/jtag_debug_port_fsm.sv
// TMS-driven shift state machine. Ports: i_TCK, i_rstn, i_TMS in;
// inISHFT, inDSHFT, inUPDATE, loadStatus out (state decodes).
module jtag_tap_fsm
  import jtag_dbg_pkg::*;
(
  input  logic i_TCK,
  input  logic i_rstn,
  input  logic i_TMS,
  output logic inISHFT,
  output logic inDSHFT,
  output logic inUPDATE,
  output logic loadStatus
);

  state_t stateQ;
  state_t stateD;

  always_ff @(posedge i_TCK or negedge i_rstn) begin
    if (!i_rstn) stateQ <= ST_IDLE;
    else         stateQ <= stateD;
  end

  always_comb begin
    stateD     = stateQ;
    inISHFT    = 1'b0;
    inDSHFT    = 1'b0;
    inUPDATE   = 1'b0;
    loadStatus = 1'b0;
    unique case (stateQ)
      ST_IDLE:   stateD = i_TMS ? ST_ISEL : ST_IDLE;
      ST_ISEL: begin
        stateD     = i_TMS ? ST_DSEL : ST_ISHFT;
        loadStatus = !i_TMS;
      end
      ST_ISHFT: begin
        stateD  = i_TMS ? ST_UPDATE : ST_ISHFT;
        inISHFT = 1'b1;
      end
      ST_DSEL:   stateD = i_TMS ? ST_IDLE : ST_DSHFT;
      ST_DSHFT: begin
        stateD  = i_TMS ? ST_IDLE : ST_DSHFT;
        inDSHFT = 1'b1;
      end
      ST_UPDATE: begin
        stateD   = ST_IDLE;
        inUPDATE = 1'b1;
      end
      default:   stateD = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/jtag_debug_port.sv
// JTAG-style debug port: shifts commands/data over TCK/TMS/TDI/TDO and
// drives memory strobes and pause/run pulses. Status word = {err,paused,booted}.
module jtag_debug_port
  import jtag_dbg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CMD_W  = 8
) (
  input  logic              i_TCK,
  input  logic              i_rstn,
  input  logic              i_TMS,
  input  logic              i_TDI,
  output logic              o_TDO,
  input  logic              i_isBooted,
  input  logic              i_isPaused,
  input  logic [DATA_W-1:0] i_memDataIn,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memDataOut,
  output logic              o_memWr,
  output logic              o_memEn,
  output logic              o_reqPause,
  output logic              o_reqRun
);

  logic              inISHFT;
  logic              inDSHFT;
  logic              inUPDATE;
  logic              loadStatus;
  logic [CMD_W-1:0]  cmdQ;
  logic [DATA_W-1:0] dataQ;
  logic [ADDR_W-1:0] addrQ;
  logic              err;
  logic [CMD_W-1:0]  statusWord;
  logic              cmdValid;
  logic              isSetAddr;
  logic              isMem;
  logic              isPause;
  logic              isRun;
  logic              memOk;
  logic              memErr;

  jtag_tap_fsm uFsm (
    .i_TCK      (i_TCK),
    .i_rstn     (i_rstn),
    .i_TMS      (i_TMS),
    .inISHFT    (inISHFT),
    .inDSHFT    (inDSHFT),
    .inUPDATE   (inUPDATE),
    .loadStatus (loadStatus)
  );

  assign cmdValid = (cmdQ[CMD_W-1:3] == '0);

  always_comb begin
    isSetAddr = 1'b0;
    isMem     = 1'b0;
    isPause   = 1'b0;
    isRun     = 1'b0;
    if (inUPDATE && cmdValid) begin
      unique case (cmdQ[2:0])
        CMD_SETADDR: isSetAddr = 1'b1;
        CMD_READ,
        CMD_WRITE,
        CMD_RDINC,
        CMD_WRINC:   isMem     = 1'b1;
        CMD_PAUSE:   isPause   = 1'b1;
        CMD_RUN:     isRun     = 1'b1;
        default:     ;
      endcase
    end
  end

  // Memory access is only legal while the core is halted.
  assign memOk  = isMem & i_isPaused;
  assign memErr = isMem & !i_isPaused;

  always_comb begin
    statusWord             = '0;
    statusWord[STS_BOOTED] = i_isBooted;
    statusWord[STS_PAUSED] = i_isPaused;
    statusWord[STS_ERR]    = err;
  end

  always_ff @(posedge i_TCK or negedge i_rstn) begin
    if (!i_rstn) begin
      cmdQ  <= '0;
      dataQ <= '0;
      addrQ <= '0;
      err   <= 1'b0;
    end else begin
      if (loadStatus)   cmdQ <= statusWord;
      else if (inISHFT) cmdQ <= {cmdQ[CMD_W-2:0], i_TDI};

      if (inDSHFT)
        dataQ <= {dataQ[DATA_W-2:0], i_TDI};
      else if (memOk && !cmdQ[0])
        dataQ <= i_memDataIn;

      if (isSetAddr)
        addrQ <= dataQ[ADDR_W-1:0];
      else if (memOk && cmdQ[2])
        addrQ <= addrQ + 1'b1;

      // Sticky; cleared when the status word is captured.
      if (memErr)          err <= 1'b1;
      else if (loadStatus) err <= 1'b0;
    end
  end

  assign o_TDO        = inDSHFT ? dataQ[DATA_W-1] : cmdQ[CMD_W-1];
  assign o_memAddr    = addrQ;
  assign o_memDataOut = dataQ;
  assign o_memWr      = cmdQ[0];
  assign o_memEn      = memOk;
  assign o_reqPause   = isPause;
  assign o_reqRun     = isRun;

endmodule

// File: tb/tb_jtag_debug_port.sv
// Directed bench for jtag_debug_port: host-side shift tasks,
// strobe events checked against a scoreboard queue.
module tb_jtag_debug_port;
  import jtag_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tms = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        booted = 1'b0;
  logic        paused = 1'b0;
  logic [15:0] rdData = 16'h0000;
  logic [15:0] memAddr;
  logic [15:0] memDataOut;
  logic        memWr;
  logic        memEn;
  logic        reqPause;
  logic        reqRun;

  int total = 0;
  int bad = 0;

  // {en, wr, pause, run, addr, data}
  typedef logic [35:0] ev_t;
  ev_t expQ[$];
  ev_t obsQ[$];

  always #5 clk = ~clk;

  jtag_debug_port dut (
    .i_TCK        (clk),
    .i_rstn       (rstn),
    .i_TMS        (tms),
    .i_TDI        (tdi),
    .o_TDO        (tdo),
    .i_isBooted   (booted),
    .i_isPaused   (paused),
    .i_memDataIn  (rdData),
    .o_memAddr    (memAddr),
    .o_memDataOut (memDataOut),
    .o_memWr      (memWr),
    .o_memEn      (memEn),
    .o_reqPause   (reqPause),
    .o_reqRun     (reqRun)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic m, input logic d);
    @(negedge clk);
    tms = m;
    tdi = d;
    @(posedge clk);
    #1;
    if (memEn)
      obsQ.push_back({1'b1, memWr, 2'b00, memAddr, memDataOut});
    else if (reqPause || reqRun)
      obsQ.push_back({2'b00, reqPause, reqRun, 32'h0});
  endtask

  task automatic shiftIr(input logic [7:0] code, output logic [7:0] st);
    st = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      st = {st[6:0], tdo};
      step(i == 7, code[7-i]);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic shiftDr(input logic [15:0] val, output logic [15:0] q);
    q = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      q = {q[14:0], tdo};
      step(i == 15, val[15-i]);
    end
  endtask

  task automatic checkEvents(input string tag);
    ev_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (obsQ.size() == 0) begin
        chk({tag, "_missing"}, 64'h0, 64'(e));
      end else begin
        chk(tag, 64'(obsQ.pop_front()), 64'(e));
      end
    end
    chk({tag, "_extra"}, 64'(obsQ.size()), 64'd0);
    obsQ.delete();
  endtask

  initial begin
    logic [7:0]  st;
    logic [15:0] q;

    // Reset values
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_tdo", 64'(tdo), 64'd0);
    chk("rst_addr", 64'(memAddr), 64'd0);
    chk("rst_data", 64'(memDataOut), 64'd0);
    chk("rst_strobes", 64'({memWr, memEn, reqPause, reqRun}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // 1) reset in the middle of a data shift
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    chk("pre_rst_data", 64'(memDataOut), 64'h1f);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_data", 64'(memDataOut), 64'd0);
    chk("midrst_tdo", 64'(tdo), 64'd0);
    chk("midrst_strobes", 64'({memEn, reqPause, reqRun}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("postrst_data", 64'(memDataOut), 64'd0);
    chk("postrst_tdo", 64'(tdo), 64'd0);
    checkEvents("rst_ev");

    // 2) status capture
    paused = 1'b1;
    booted = 1'b1;
    shiftIr({5'b0, CMD_NOP}, st);
    chk("status_first", 64'(st), 64'h03);

    // 3) address set and burst writes
    shiftDr(16'h00FF, q);
    shiftIr({5'b0, CMD_SETADDR}, st);
    chk("setaddr_ff", 64'(memAddr), 64'h00FF);
    shiftDr(16'hBEEF, q);
    expQ.push_back({1'b1, 1'b1, 2'b00, 16'h00FF, 16'hBEEF});
    shiftIr({5'b0, CMD_WRINC}, st);
    checkEvents("wr1");
    chk("wr_memwr", 64'(memWr), 64'd1);
    shiftDr(16'h1234, q);
    chk("dr_readback", 64'(q), 64'hBEEF);
    expQ.push_back({1'b1, 1'b1, 2'b00, 16'h0100, 16'h1234});
    shiftIr({5'b0, CMD_WRINC}, st);
    checkEvents("wr2");
    chk("burst_addr", 64'(memAddr), 64'h0101);

    // 4) read with address wrap
    shiftDr(16'hFFFF, q);
    shiftIr({5'b0, CMD_SETADDR}, st);
    chk("setaddr_ffff", 64'(memAddr), 64'hFFFF);
    rdData = 16'hA5A5;
    expQ.push_back({1'b1, 1'b0, 2'b00, 16'hFFFF, 16'hFFFF});
    shiftIr({5'b0, CMD_RDINC}, st);
    checkEvents("rd1");
    chk("rd_data", 64'(memDataOut), 64'hA5A5);
    chk("rd_wrap", 64'(memAddr), 64'h0000);
    shiftDr(16'h5A5A, q);
    chk("rd_shiftout", 64'(q), 64'hA5A5);

    // 5) memory access while running sets the sticky error
    paused = 1'b0;
    shiftIr({5'b0, CMD_READ}, st);
    chk("status_run", 64'(st), 64'h01);
    checkEvents("noacc");
    chk("noacc_addr", 64'(memAddr), 64'h0000);
    chk("noacc_data", 64'(memDataOut), 64'h5A5A);
    shiftIr({5'b0, CMD_NOP}, st);
    chk("status_err", 64'(st), 64'h05);
    shiftIr({5'b0, CMD_NOP}, st);
    chk("status_clr", 64'(st), 64'h01);

    // 6) run control pulses and an invalid command
    paused = 1'b1;
    expQ.push_back({2'b00, 1'b1, 1'b0, 32'h0});
    shiftIr({5'b0, CMD_PAUSE}, st);
    checkEvents("pause");
    expQ.push_back({2'b00, 1'b0, 1'b1, 32'h0});
    shiftIr({5'b0, CMD_RUN}, st);
    checkEvents("run");
    shiftIr(8'h83, st);
    checkEvents("invalid");
    chk("invalid_data", 64'(memDataOut), 64'h5A5A);
    shiftIr({5'b0, CMD_NOP}, st);
    chk("status_final", 64'(st), 64'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
